// File: rtl/mipi_csi_pkg.sv
// Shared definitions for the CSI-2 receive lane alignment path.
package mipi_csi_pkg;

    localparam int MIPI_GEAR_DEF = 8;
    localparam int LANES_DEF     = 4;

    // Byte the per-lane aligners raise valid on.
    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/mipi_csi_rx_lane_aligner_if.sv
// Byte-stream bundle between the per-lane byte aligners, the lane aligner and the packet decoder.
interface mipi_csi_rx_lane_aligner_if
    import mipi_csi_pkg::*;
#(
    parameter int LANES     = LANES_DEF,
    parameter int MIPI_GEAR = MIPI_GEAR_DEF
);

    logic [LANES-1:0]           bytes_valid_i;
    logic [LANES*MIPI_GEAR-1:0] byte_i;
    logic                       lane_valid_o;
    logic [LANES*MIPI_GEAR-1:0] lane_byte_o;

    // Upstream side: drives the skewed lane bytes, observes the aligned word.
    modport master (
        output bytes_valid_i,
        output byte_i,
        input  lane_valid_o,
        input  lane_byte_o
    );

    // Aligner side.
    modport slave (
        input  bytes_valid_i,
        input  byte_i,
        output lane_valid_o,
        output lane_byte_o
    );

endinterface

// File: rtl/mipi_rx_lane_delay.sv
// One lane's delay line: byte history, skew counter and the tap that picks the aligned byte.
module mipi_rx_lane_delay
    import mipi_csi_pkg::*;
#(
    parameter int MIPI_GEAR   = MIPI_GEAR_DEF,
    parameter int ALIGN_DEPTH = 7
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 valid_i,
    input  logic                 lock_i,
    input  logic                 unlock_i,
    input  logic [MIPI_GEAR-1:0] byte_i,
    output logic [MIPI_GEAR-1:0] tap_byte_o
);

    localparam int             CW      = $clog2(ALIGN_DEPTH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(ALIGN_DEPTH - 1);

    logic [MIPI_GEAR-1:0] hist_q [1:ALIGN_DEPTH-1];
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        tap_q, tap_d;
    logic [CW-1:0]        sel;

    // History shifts every cycle; hist_q[k] is the byte from k cycles ago.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 1; k < ALIGN_DEPTH; k++) hist_q[k] <= '0;
        end else begin
            hist_q[1] <= byte_i;
            for (int k = 2; k < ALIGN_DEPTH; k++) hist_q[k] <= hist_q[k-1];
        end
    end

    // Skew counter counts cycles since this lane's sync byte; tap is captured at lock.
    // Counting while locked is harmless: the counter is only read on the lock cycle
    // and unlock (all lanes idle) clears it.
    always_comb begin
        if (unlock_i || !valid_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (unlock_i) begin
            tap_d = '0;
        end else if (lock_i) begin
            tap_d = cnt_q;
        end else begin
            tap_d = tap_q;
        end
    end

    // Counter and tap registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            tap_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tap_q <= tap_d;
        end
    end

    // Tap mux; on the lock cycle the tap register is not loaded yet, so use the counter directly.
    always_comb begin
        sel        = lock_i ? cnt_q : tap_q;
        tap_byte_o = byte_i;
        for (int k = 1; k < ALIGN_DEPTH; k++) begin
            if (sel == CW'(k)) tap_byte_o = hist_q[k];
        end
    end

endmodule

// File: rtl/mipi_csi_rx_lane_aligner.sv
// Deskews the CSI-2 lane byte streams so every lane's sync byte leaves on the same cycle.
module mipi_csi_rx_lane_aligner
    import mipi_csi_pkg::*;
#(
    parameter int MIPI_GEAR   = MIPI_GEAR_DEF,
    parameter int LANES       = LANES_DEF,
    parameter int ALIGN_DEPTH = 7
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    mipi_csi_rx_lane_aligner_if.slave bus
);

    localparam int W = LANES * MIPI_GEAR;

    lock_state_e  state_q, state_d;
    logic         all_vld, none_vld;
    logic         lock, unlock;
    logic         armed_q, armed_d;
    logic         lane_valid_q, lane_valid_d;
    logic [W-1:0] lane_byte_q, lane_byte_d;
    logic [W-1:0] tap_bytes;

    assign all_vld  = &bus.bytes_valid_i;
    assign none_vld = ~|bus.bytes_valid_i;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mipi_rx_lane_delay #(
            .MIPI_GEAR   (MIPI_GEAR),
            .ALIGN_DEPTH (ALIGN_DEPTH)
        ) u_delay (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .valid_i    (bus.bytes_valid_i[i]),
            .lock_i     (lock),
            .unlock_i   (unlock),
            .byte_i     (bus.byte_i[i*MIPI_GEAR +: MIPI_GEAR]),
            .tap_byte_o (tap_bytes[i*MIPI_GEAR +: MIPI_GEAR])
        );
    end

    // Lock state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= ST_UNLOCKED;
        else         state_q <= state_d;
    end

    // Lock when every lane is valid (only after an all-idle cycle), unlock when all lanes are idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNLOCKED: if (armed_q && all_vld) state_d = ST_LOCKED;
            ST_LOCKED:   if (none_vld)           state_d = ST_UNLOCKED;
            default:     state_d = ST_UNLOCKED;
        endcase
    end

    // Lock/unlock strobes, re-arm tracking and next output word.
    // Armed is cleared by reset so a burst interrupted by reset cannot re-lock mid-stream.
    always_comb begin
        lock    = (state_q == ST_UNLOCKED) && (state_d == ST_LOCKED);
        unlock  = (state_q == ST_LOCKED)   && (state_d == ST_UNLOCKED);
        armed_d = armed_q;
        if (none_vld)  armed_d = 1'b1;
        else if (lock) armed_d = 1'b0;
        lane_valid_d = (state_d == ST_LOCKED);
        lane_byte_d  = (state_d == ST_LOCKED) ? tap_bytes : lane_byte_q;
    end

    // Output and arm registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            armed_q      <= 1'b0;
            lane_valid_q <= 1'b0;
            lane_byte_q  <= '0;
        end else begin
            armed_q      <= armed_d;
            lane_valid_q <= lane_valid_d;
            lane_byte_q  <= lane_byte_d;
        end
    end

    assign bus.lane_valid_o = lane_valid_q;
    assign bus.lane_byte_o  = lane_byte_q;

endmodule

// File: tb/tb_mipi_csi_rx_lane_aligner.sv
// Randomized bench for the lane aligner, checked against a time-indexed reference model.
module tb_mipi_csi_rx_lane_aligner;

    localparam int LANES = 4;
    localparam int GEAR  = 8;
    localparam int DEPTH = 7;
    localparam int W     = LANES * GEAR;
    localparam int MAXC  = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mipi_csi_rx_lane_aligner_if #(.LANES(LANES), .MIPI_GEAR(GEAR)) bus ();

    mipi_csi_rx_lane_aligner #(
        .MIPI_GEAR   (GEAR),
        .LANES       (LANES),
        .ALIGN_DEPTH (DEPTH)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    // Everything ever driven, indexed by cycle.
    logic [7:0] byte_log [LANES][MAXC];
    bit         vld_log  [LANES][MAXC];

    int           cyc      = 0;
    int           last_rst = 0;
    bit           m_locked = 0;
    bit           m_armed  = 0;
    bit           just_locked = 0;
    bit           check_sync  = 1;
    int           m_tap [LANES];
    logic         exp_vld  = 1'b0;
    logic [W-1:0] exp_byte = '0;
    int           sk [LANES];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Byte lane i carried k cycles before cycle c; history older than the last reset reads as 0.
    function automatic logic [7:0] past(input int lane, input int c, input int k);
        if (k == 0) return byte_log[lane][c];
        if (c - k > last_rst) return byte_log[lane][c-k];
        return 8'h00;
    endfunction

    function automatic logic [W-1:0] aligned_word(input int c);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < LANES; i++) w[i*GEAR +: GEAR] = past(i, c, m_tap[i]);
        return w;
    endfunction

    // Expected outputs after the edge that samples cycle cyc's inputs.
    task automatic model_edge(input bit r, input logic [LANES-1:0] v);
        int rs;
        int skew;
        just_locked = 0;
        if (r) begin
            m_locked = 0;
            m_armed  = 0;
            last_rst = cyc;
            exp_vld  = 1'b0;
            exp_byte = '0;
        end else if (!m_locked) begin
            if (m_armed && (&v)) begin
                for (int i = 0; i < LANES; i++) begin
                    rs = cyc;
                    while (rs - 1 > last_rst && vld_log[i][rs-1]) rs--;
                    skew = cyc - rs;
                    if (skew > DEPTH - 1) skew = DEPTH - 1;
                    m_tap[i] = skew;
                end
                m_locked    = 1;
                m_armed     = 0;
                just_locked = 1;
                exp_vld     = 1'b1;
                exp_byte    = aligned_word(cyc);
            end else begin
                if (v == '0) m_armed = 1;
                exp_vld = 1'b0;
            end
        end else if (v == '0) begin
            m_locked = 0;
            m_armed  = 1;
            exp_vld  = 1'b0;
        end else begin
            exp_vld  = 1'b1;
            exp_byte = aligned_word(cyc);
        end
    endtask

    task automatic step(input bit r, input logic [LANES-1:0] v, input logic [W-1:0] b);
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d cycles expected below %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        rst               = r;
        bus.bytes_valid_i = v;
        bus.byte_i        = b;
        for (int i = 0; i < LANES; i++) begin
            byte_log[i][cyc] = b[i*GEAR +: GEAR];
            vld_log[i][cyc]  = v[i];
        end
        model_edge(r, v);
        @(posedge clk);
        #1;
        chk("lane_valid_o", 64'(bus.lane_valid_o), 64'(exp_vld));
        chk("lane_byte_o", 64'(bus.lane_byte_o), 64'(exp_byte));
        if (just_locked && check_sync) chk("sync_word", 64'(bus.lane_byte_o), 64'({LANES{8'hB8}}));
        cyc++;
    endtask

    task automatic idle(input int n, input bit zeros);
        logic [W-1:0] b;
        for (int t = 0; t < n; t++) begin
            b = '0;
            if (!zeros) for (int i = 0; i < LANES; i++) b[i*GEAR +: GEAR] = 8'($urandom);
            step(1'b0, '0, b);
        end
    endtask

    // Lane i is valid for n+1 cycles starting at offset sk[i]: sync byte, then n payload bytes.
    task automatic burst(input int n, input bit rnd, input int rst_at);
        int maxs;
        int j;
        logic [LANES-1:0] v;
        logic [W-1:0]     b;
        maxs = 0;
        for (int i = 0; i < LANES; i++) if (sk[i] > maxs) maxs = sk[i];
        for (int t = 0; t < maxs + n + 3; t++) begin
            v = '0;
            for (int i = 0; i < LANES; i++) begin
                j = t - sk[i];
                if (j >= 0 && j <= n) begin
                    v[i] = 1'b1;
                    if (j == 0)   b[i*GEAR +: GEAR] = 8'hB8;
                    else if (rnd) b[i*GEAR +: GEAR] = 8'($urandom);
                    else          b[i*GEAR +: GEAR] = 8'(j * 8'h11);
                end else begin
                    b[i*GEAR +: GEAR] = 8'($urandom);
                end
            end
            step(t == rst_at, v, b);
        end
    endtask

    initial begin
        int n;
        int rst_at;
        bus.bytes_valid_i = '0;
        bus.byte_i        = '0;

        // Reset, then idle zeros.
        step(1'b1, '0, '0);
        step(1'b1, '0, '0);
        idle(4, 1'b1);

        // Skew 5: lane1 first, lanes 2/3 four cycles later, lane 0 one after that.
        sk = '{5, 0, 4, 4};
        burst(9, 1'b0, -1);
        idle(6, 1'b0);

        // Re-lock with a different skew.
        sk = '{3, 0, 2, 2};
        burst(9, 1'b0, -1);
        idle(3, 1'b0);

        // Zero skew.
        sk = '{0, 0, 0, 0};
        burst(9, 1'b1, -1);
        idle(3, 1'b0);

        // Reset while locked, lanes keep streaming afterwards.
        sk = '{2, 0, 1, 3};
        burst(12, 1'b1, 8);
        idle(3, 1'b0);
        sk = '{1, 1, 0, 2};
        burst(6, 1'b1, -1);
        idle(2, 1'b0);

        // Out-of-range skew: counter saturates, output misaligned but still modelled.
        check_sync = 0;
        sk = '{8, 0, 0, 0};
        burst(12, 1'b1, -1);
        idle(3, 1'b0);
        check_sync = 1;

        // Random skews, lengths, data and occasional resets.
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < LANES; i++) sk[i] = $urandom_range(0, DEPTH - 1);
            n      = $urandom_range(1, 14);
            rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1;
            burst(n, 1'b1, rst_at);
            idle($urandom_range(0, 4), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
